// File: rtl/lab61soc_pio_pkg.sv
// Shared register map and edge-select encodings for the button/switch input PIO.
package lab61soc_pio_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_RSVD    = 2'd1;
   localparam logic [1:0] REG_IRQMASK = 2'd2;
   localparam logic [1:0] REG_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/lab61soc_pio_debounce.sv
// One input bit: multi-flop synchroniser followed by a stable-count debouncer.
module lab61soc_pio_debounce #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic RESET_BIT       = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic deb
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= {SYNC_STAGES{RESET_BIT}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_q = sync_r[SYNC_STAGES-1];

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb <= RESET_BIT;
            end else begin
               deb <= sync_q;
            end
         end
      end else begin : g_count
         localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
         localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

         logic [CW-1:0] cnt;

         // Any return to the current debounced level restarts the stability window.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               deb <= RESET_BIT;
               cnt <= '0;
            end else if (sync_q == deb) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               deb <= sync_q;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/lab61soc_button_pio_irq.sv
// Avalon-MM input PIO: debounced pins, edge capture with write-1-to-clear, maskable level IRQ.
module lab61soc_button_pio_irq
   import lab61soc_pio_pkg::*;
#(
   parameter int               WIDTH           = 2,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 500000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] deb;
   logic [WIDTH-1:0] deb_d;
   logic [WIDTH-1:0] edge_v;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic [31:0]      rd_next;
   logic             wr;
   logic             unused_wdata;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      lab61soc_pio_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_BIT       (RESET_VALUE[i])
      ) u_deb (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (in_port[i]),
         .deb     (deb[i])
      );
   end

   assign wr           = chipselect & ~write_n;
   assign clr          = (wr && address == REG_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wdata = ^writedata;

   always_comb begin
      edge_v = '0;
      if (EDGE_TYPE == EDGE_RISE) begin
         edge_v = deb & ~deb_d;
      end else if (EDGE_TYPE == EDGE_FALL) begin
         edge_v = ~deb & deb_d;
      end else begin
         edge_v = deb ^ deb_d;
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         REG_DATA:    rd_next[WIDTH-1:0] = deb;
         REG_RSVD:    rd_next            = '0;
         REG_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
         REG_EDGECAP: rd_next[WIDTH-1:0] = edgecapture;
         default:     rd_next            = '0;
      endcase
   end

   // A fresh edge in the same cycle as its clear keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_d       <= RESET_VALUE;
         irqmask     <= '0;
         edgecapture <= '0;
         readdata    <= '0;
         irq         <= 1'b0;
      end else begin
         deb_d       <= deb;
         edgecapture <= edge_v | (edgecapture & ~clr);
         readdata    <= rd_next;
         irq         <= |(edgecapture & irqmask);
         if (wr && address == REG_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
         end
      end
   end

endmodule

// File: tb/tb_lab61soc_button_pio_irq.sv
// Directed bench for the button PIO: falling-edge instance plus an any-edge instance on a shared bus.
module tb_lab61soc_button_pio_irq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [1:0]  in_port;
   logic [31:0] readdata;
   logic        irq;
   logic [31:0] readdata2;
   logic        irq2;
   logic [31:0] d1;
   logic [31:0] d2;

   int checks   = 0;
   int failures = 0;

   lab61soc_button_pio_irq #(
      .WIDTH (2), .SYNC_STAGES (2), .DEBOUNCE_CYCLES (4), .EDGE_TYPE (1), .RESET_VALUE (2'b11)
   ) dut (
      .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
      .write_n (write_n), .writedata (writedata), .in_port (in_port),
      .readdata (readdata), .irq (irq)
   );

   lab61soc_button_pio_irq #(
      .WIDTH (2), .SYNC_STAGES (2), .DEBOUNCE_CYCLES (4), .EDGE_TYPE (2), .RESET_VALUE (2'b11)
   ) dut_any (
      .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
      .write_n (write_n), .writedata (writedata), .in_port (in_port),
      .readdata (readdata2), .irq (irq2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] r1, output logic [31:0] r2);
      address = a;
      tick();
      r1 = readdata;
      r2 = readdata2;
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 2'b11;
      ticks(3);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'd0, irq}, 32'h0);
      reset_n = 1'b1;

      // Reset values
      bus_read(2'd0, d1, d2);
      check("rst_data", d1, 32'h3);
      bus_read(2'd2, d1, d2);
      check("rst_mask", d1, 32'h0);
      bus_read(2'd3, d1, d2);
      check("rst_edgecap", d1, 32'h0);
      bus_read(2'd1, d1, d2);
      check("rsvd_zero", d1, 32'h0);

      // 3-cycle glitch is filtered
      in_port = 2'b10;
      ticks(3);
      in_port = 2'b11;
      ticks(10);
      bus_read(2'd0, d1, d2);
      check("glitch_data", d1, 32'h3);
      bus_read(2'd3, d1, d2);
      check("glitch_edgecap", d1, 32'h0);

      // Held press is debounced and captured
      in_port = 2'b10;
      ticks(10);
      bus_read(2'd0, d1, d2);
      check("press_data", d1, 32'h2);
      bus_read(2'd3, d1, d2);
      check("press_edgecap", d1, 32'h1);
      check("press_irq_masked", {31'd0, irq}, 32'h0);

      // IRQ enable, then W1C
      bus_write(2'd2, 32'h1);
      check("irq_lag_mask", {31'd0, irq}, 32'h0);
      tick();
      check("irq_on", {31'd0, irq}, 32'h1);
      bus_write(2'd3, 32'h1);
      check("irq_lag_clr", {31'd0, irq}, 32'h1);
      tick();
      check("irq_off", {31'd0, irq}, 32'h0);
      bus_read(2'd3, d1, d2);
      check("w1c_edgecap", d1, 32'h0);
      bus_read(2'd2, d1, d2);
      check("mask_rd", d1, 32'h1);

      // Bit 1 fall captured, rise ignored, then a W1C timed onto a new fall
      in_port = 2'b00;
      ticks(10);
      bus_read(2'd3, d1, d2);
      check("fall1_edgecap", d1, 32'h2);
      in_port = 2'b10;
      ticks(10);
      bus_read(2'd3, d1, d2);
      check("rise_ignored", d1, 32'h2);
      in_port = 2'b00;
      ticks(6);
      bus_write(2'd3, 32'h2);
      bus_read(2'd3, d1, d2);
      check("collision_edgecap", d1, 32'h2);
      bus_read(2'd0, d1, d2);
      check("collision_data", d1, 32'h0);

      // Masking
      check("masked_irq", {31'd0, irq}, 32'h0);
      bus_write(2'd2, 32'h3);
      tick();
      check("unmasked_irq", {31'd0, irq}, 32'h1);
      bus_write(2'd0, 32'hFFFF_FFFF);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd2, d1, d2);
      check("addr0_mask", d1, 32'h3);
      bus_read(2'd3, d1, d2);
      check("addr0_edgecap", d1, 32'h2);
      bus_read(2'd0, d1, d2);
      check("addr0_data", d1, 32'h0);
      check("addr0_irq", {31'd0, irq}, 32'h1);
      bus_write(2'd2, 32'hFFFF_FFFC);
      tick();
      check("upper_bits_irq", {31'd0, irq}, 32'h0);
      bus_read(2'd2, d1, d2);
      check("upper_bits_mask", d1, 32'h0);

      // Reset while bit 1 counter sits at 2
      in_port = 2'b11;
      ticks(10);
      in_port = 2'b01;
      address = 2'd0;
      ticks(4);
      reset_n = 1'b0;
      tick();
      check("midrst_readdata", readdata, 32'h0);
      reset_n = 1'b1;
      ticks(6);
      check("midrst_hold", readdata, 32'h3);
      tick();
      check("midrst_change", readdata, 32'h1);
      ticks(3);
      bus_read(2'd3, d1, d2);
      check("midrst_edgecap", d1, 32'h2);
      check("any_fall_edgecap", d2, 32'h2);
      bus_read(2'd2, d1, d2);
      check("midrst_mask", d1, 32'h0);
      bus_write(2'd3, 32'h3);
      bus_read(2'd3, d1, d2);
      check("any_clr_edgecap", d2, 32'h0);

      // Any-edge: press then release, each captured after its own W1C
      in_port = 2'b00;
      ticks(10);
      bus_read(2'd3, d1, d2);
      check("any_press", d2, 32'h1);
      check("fall_press", d1, 32'h1);
      bus_write(2'd3, 32'h1);
      bus_read(2'd3, d1, d2);
      check("any_press_clr", d2, 32'h0);
      in_port = 2'b01;
      ticks(10);
      bus_read(2'd3, d1, d2);
      check("any_release", d2, 32'h1);
      check("fall_release", d1, 32'h0);
      check("any_irq_masked", {31'd0, irq2}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
